// File: rtl/cga_pkg.sv
// Purpose: shared colour constants, 320-mode palette, counter decode points and cell types for the CGA sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cga_pkg;

    // IRGB colour codes (bit3 = intensity, bit2 = R, bit1 = G, bit0 = B)
    localparam logic [3:0] C_BLACK   = 4'h0;
    localparam logic [3:0] C_GREEN   = 4'h2;
    localparam logic [3:0] C_CYAN    = 4'h3;
    localparam logic [3:0] C_RED     = 4'h4;
    localparam logic [3:0] C_MAGENTA = 4'h5;
    localparam logic [3:0] C_BROWN   = 4'h6;
    localparam logic [3:0] C_WHITE   = 4'h7;

    // Dot-counter decode points
    localparam logic [3:0] CNT_HCLK = 4'd15;
    localparam logic [4:0] CNT_LCLK = 5'd31;

    // 320-mode palette: [pal_sel][pixel value]; entry 0 is replaced by the background colour
    localparam logic [3:0] PAL320 [2][4] = '{
        '{C_BLACK, C_GREEN, C_RED,     C_BROWN},
        '{C_BLACK, C_CYAN,  C_MAGENTA, C_WHITE}
    };

    typedef enum logic [1:0] {
        MODE_T40  = 2'd0,
        MODE_T80  = 2'd1,
        MODE_G320 = 2'd2,
        MODE_G640 = 2'd3
    } mode_t;

    // Per-cell colour state captured at load
    typedef struct packed {
        logic       en;
        logic       cur;
        logic [3:0] fg;
        logic [3:0] bg;
        logic [4:0] csel;
        logic       pal;
    } cell_t;

    function automatic mode_t mode_decode(input logic hres, input logic grph, input logic g640);
        if (grph) begin
            return g640 ? MODE_G640 : MODE_G320;
        end
        return hres ? MODE_T80 : MODE_T40;
    endfunction

    function automatic logic [3:0] pal320_px(input logic [4:0] csel, input logic pal, input logic [1:0] v);
        logic [3:0] c;
        c = PAL320[pal][v];
        return (v == 2'd0) ? csel[3:0] : {csel[4], c[2:0]};
    endfunction

endpackage

// File: rtl/cga_sequencer_if.sv
// Purpose: bundles the CGA sequencer mode, fetch-data, strobe and pixel signals.
// Latency: n/a (wiring only).
// Backpressure: none; the sequencer is free-running and never stalls.
interface cga_sequencer_if;
    logic       hres_mode;
    logic       grph_mode;
    logic       grph_640;
    logic       display_enable;
    logic       cursor;
    logic       blink;
    logic [7:0] char_byte;   // carried for the external font fetch; pixels come from pix_byte
    logic [7:0] attr_byte;
    logic [7:0] pix_byte;
    logic [4:0] color_sel;
    logic       pal_sel;
    logic       load;
    logic       hclk;
    logic       lclk;
    logic       pix_ce;
    logic [3:0] video;

    modport master (
        output hres_mode, grph_mode, grph_640, display_enable, cursor, blink,
               char_byte, attr_byte, pix_byte, color_sel, pal_sel,
        input  load, hclk, lclk, pix_ce, video
    );

    modport slave (
        input  hres_mode, grph_mode, grph_640, display_enable, cursor, blink,
               char_byte, attr_byte, pix_byte, color_sel, pal_sel,
        output load, hclk, lclk, pix_ce, video
    );
endinterface

// File: rtl/cga_clk_en.sv
// Purpose: 5-bit dot counter and decode of hclk/lclk/pix_ce/load for the active (latched) mode.
// Latency: strobes decode directly from the counter register; first hclk 16 clk, first lclk 32 clk after reset.
// Backpressure: none; free-running.
module cga_clk_en
    import cga_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  mode_t i_mode,
    output logic  o_hclk,
    output logic  o_lclk,
    output logic  o_pix_ce,
    output logic  o_load
);

    logic [4:0] r_cnt;
    logic       w_hclk;
    logic       w_lclk;
    logic       w_fast;

    // Free-running dot counter, wraps 31 -> 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 5'd0;
        end else begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign w_hclk = (r_cnt[3:0] == CNT_HCLK);
    assign w_lclk = (r_cnt == CNT_LCLK);
    // 80-column text and 640 graphics run two clocks per pixel, the others four
    assign w_fast = (i_mode == MODE_T80) || (i_mode == MODE_G640);

    assign o_hclk   = w_hclk;
    assign o_lclk   = w_lclk;
    assign o_pix_ce = w_fast ? r_cnt[0] : (r_cnt[1:0] == 2'b11);
    assign o_load   = (i_mode == MODE_T40) ? w_lclk : w_hclk;

endmodule

// File: rtl/cga_sequencer.sv
// Purpose: CGA pixel sequencer: latches cell colour state at load, shifts pix_byte and emits IRGB pixels. Option: CGA_BLINK_EN.
// Latency: video updates 1 clk after each pix_ce; the pix_ce coincident with load emits pixel 0 of the new cell.
// Backpressure: none; free-running, the fetch side must present data on the load cycle.
module cga_sequencer
    import cga_pkg::*;
(
    input logic            clk,
    input logic            reset,
    cga_sequencer_if.slave bus
);

    mode_t      r_mode;
    mode_t      w_mode_live;
    mode_t      w_mode;
    logic       r_run;
    logic       w_mode_lat;
    logic       w_hclk;
    logic       w_lclk;
    logic       w_pix_ce;
    logic       w_load;
    cell_t      r_cell;
    cell_t      w_cell_new;
    cell_t      w_cell;
    logic [7:0] r_shift;
    logic [7:0] w_src;
    logic [3:0] r_video;
    logic [3:0] w_px;

    cga_clk_en u_clk_en (
        .clk      (clk),
        .reset    (reset),
        .i_mode   (r_mode),
        .o_hclk   (w_hclk),
        .o_lclk   (w_lclk),
        .o_pix_ce (w_pix_ce),
        .o_load   (w_load)
    );

    // Mode only switches on a 32-clk boundary (lclk is always a load), so a 40/80 change can
    // never cut a cell short; the first clock after reset also samples it to start cleanly.
    assign w_mode_live = mode_decode(bus.hres_mode, bus.grph_mode, bus.grph_640);
    assign w_mode_lat  = w_lclk || !r_run;
    assign w_mode      = w_mode_lat ? w_mode_live : r_mode;

    // Cell colour state as a load on this cycle would capture it
    always_comb begin
        w_cell_new      = '0;
        w_cell_new.en   = bus.display_enable;
        w_cell_new.cur  = bus.cursor && bus.blink;
        w_cell_new.csel = bus.color_sel;
        w_cell_new.pal  = bus.pal_sel;
`ifdef CGA_BLINK_EN
        w_cell_new.bg   = {1'b0, bus.attr_byte[6:4]};
        w_cell_new.fg   = (bus.attr_byte[7] && !bus.blink) ? {1'b0, bus.attr_byte[6:4]}
                                                           : bus.attr_byte[3:0];
`else
        w_cell_new.bg   = bus.attr_byte[7:4];
        w_cell_new.fg   = bus.attr_byte[3:0];
`endif
    end

    // On load the new cell's state and byte are used directly so pixel 0 appears without delay
    assign w_cell = w_load ? w_cell_new : r_cell;
    assign w_src  = w_load ? bus.pix_byte : r_shift;

    // Pixel colour for the current pix_ce; a disabled cell ignores cursor and data
    always_comb begin
        w_px = C_BLACK;
        if (!w_cell.en) begin
            w_px = (w_mode == MODE_G640) ? C_BLACK : w_cell.csel[3:0];
        end else begin
            case (w_mode)
                MODE_G320: w_px = pal320_px(w_cell.csel, w_cell.pal, w_src[7:6]);
                MODE_G640: w_px = w_src[7] ? w_cell.csel[3:0] : C_BLACK;
                default:   w_px = (w_cell.cur || w_src[7]) ? w_cell.fg : w_cell.bg;
            endcase
        end
    end

    // Mode latch, held until the next 32-clk boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= MODE_T40;
            r_run  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_mode_lat) begin
                r_mode <= w_mode_live;
            end
        end
    end

    // Cell latch, shifter and registered pixel output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cell  <= '0;
            r_shift <= 8'h00;
            r_video <= 4'h0;
        end else begin
            if (w_load) begin
                r_cell <= w_cell_new;
            end
            if (w_pix_ce) begin
                r_shift <= (w_mode == MODE_G320) ? {w_src[5:0], 2'b00} : {w_src[6:0], 1'b0};
                r_video <= w_px;
            end
        end
    end

    assign bus.load   = w_load;
    assign bus.hclk   = w_hclk;
    assign bus.lclk   = w_lclk;
    assign bus.pix_ce = w_pix_ce;
    assign bus.video  = r_video;

endmodule

// File: tb/tb_cga_sequencer.sv
// Purpose: self-checking bench for cga_sequencer; expected pixels are queued per cell and popped by a monitor.
// Latency: monitor compares video 1 clk after every sampled pix_ce.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_cga_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_e;

    always #5 clk = ~clk;

    cga_sequencer_if bus ();

    cga_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pix_ce produces a pixel one clock later; compare it when one is expected
    always @(negedge clk) begin
        if (!reset && bus.pix_ce === 1'b1) begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("video", 32'(bus.video), 32'(mon_e));
            end
        end
    end

    // k = clock edges since reset release, i.e. counter value; a strobe seen here is consumed at edge k+1
    task automatic check_strobes(input string tag, input int k, input bit fast);
        bit eh, el;
        eh = (k % 16 == 15);
        el = (k % 32 == 31);
        check({tag, "_hclk"}, 32'(bus.hclk), 32'(eh));
        check({tag, "_lclk"}, 32'(bus.lclk), 32'(el));
        check({tag, "_pix_ce"}, 32'(bus.pix_ce), fast ? 32'(k % 2 == 1) : 32'(k % 4 == 3));
        check({tag, "_load"}, 32'(bus.load), fast ? 32'(eh) : 32'(el));
    endtask

    task automatic set_inputs(input int md, input bit en, input bit cur, input bit blk,
                              input logic [7:0] attr, input logic [7:0] pix,
                              input logic [4:0] csel, input bit pal);
        bus.hres_mode      = (md == 1);
        bus.grph_mode      = (md >= 2);
        bus.grph_640       = (md == 3);
        bus.display_enable = en;
        bus.cursor         = cur;
        bus.blink          = blk;
        bus.char_byte      = 8'h41;
        bus.attr_byte      = attr;
        bus.pix_byte       = pix;
        bus.color_sel      = csel;
        bus.pal_sel        = pal;
    endtask

    // Start a cell at the next 32-clk load, queue its pixels, then measure cell length and pixel count.
    // md: 0 = 40-col text, 1 = 80-col text, 2 = 320 graphics, 3 = 640 graphics
    task automatic run_cell(input string name, input int md, input bit en, input bit cur, input bit blk,
                            input logic [7:0] attr, input logic [7:0] pix, input logic [4:0] csel,
                            input bit pal, input logic [31:0] px, input int n, input bit flip);
        bit hit;
        int cyc;
        int pcnt;
        set_inputs(md, en, cur, blk, attr, pix, csel, pal);
        hit = 1'b0;
        for (int i = 0; i < 70 && !hit; i++) begin
            @(negedge clk);
            hit = (bus.load === 1'b1) && (bus.lclk === 1'b1);
        end
        if (!hit) begin
            check({name, "_lclk_timeout"}, 32'(hit), 32'(1));
            return;
        end
        for (int i = 0; i < n; i++) exp_q.push_back(px[31 - 4*i -: 4]);
        cyc  = 0;
        pcnt = 0;
        hit  = 1'b0;
        for (int i = 0; i < 70 && !hit; i++) begin
            @(negedge clk);
            cyc++;
            if (flip && cyc == 2) bus.hres_mode = ~bus.hres_mode;
            if (bus.load === 1'b1) hit = 1'b1;
            else if (bus.pix_ce === 1'b1) pcnt++;
        end
        check({name, "_cell_len"}, 32'(cyc), (md == 0) ? 32'd32 : 32'd16);
        check({name, "_pix_count"}, 32'(pcnt), 32'(n - 1));
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        set_inputs(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b0);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_video",  32'(bus.video),  32'h0);
        check("rst_load",   32'(bus.load),   32'h0);
        check("rst_hclk",   32'(bus.hclk),   32'h0);
        check("rst_lclk",   32'(bus.lclk),   32'h0);
        check("rst_pix_ce", 32'(bus.pix_ce), 32'h0);

        // Strobe timing out of reset in 80-col text: hclk consumed at edges 16/32/48, lclk at 32/64
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            check_strobes("boot", k, 1'b1);
        end

        // Pixel cells
        run_cell("t80",     1, 1'b1, 1'b0, 1'b0, 8'h1E, 8'hA5, 5'h00, 1'b0, 32'hE1E11E1E, 8, 1'b0);
        run_cell("g320p1",  2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h1B, 5'h11, 1'b1, 32'h1BDF0000, 4, 1'b0);
        run_cell("g320p0",  2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h1B, 5'h11, 1'b0, 32'h1ACE0000, 4, 1'b0);
        run_cell("t40cur",  0, 1'b1, 1'b1, 1'b1, 8'h07, 8'h00, 5'h0C, 1'b0, 32'h77777777, 8, 1'b0);
        run_cell("t40off",  0, 1'b0, 1'b1, 1'b1, 8'h07, 8'h00, 5'h0C, 1'b0, 32'hCCCCCCCC, 8, 1'b0);
        run_cell("g640",    3, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 5'h09, 1'b0, 32'h99000099, 8, 1'b0);
        run_cell("g640off", 3, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 5'h09, 1'b0, 32'h00000000, 8, 1'b0);
`ifdef CGA_BLINK_EN
        run_cell("blink",   1, 1'b1, 1'b0, 1'b0, 8'h8F, 8'hFF, 5'h00, 1'b0, 32'h00000000, 8, 1'b0);
        run_cell("bgint",   0, 1'b1, 1'b0, 1'b1, 8'hC2, 8'h0F, 5'h00, 1'b0, 32'h44442222, 8, 1'b0);
`else
        run_cell("blink",   1, 1'b1, 1'b0, 1'b0, 8'h8F, 8'hFF, 5'h00, 1'b0, 32'hFFFFFFFF, 8, 1'b0);
        run_cell("bgint",   0, 1'b1, 1'b0, 1'b1, 8'hC2, 8'h0F, 5'h00, 1'b0, 32'hCCCC2222, 8, 1'b0);
`endif
        // 40-col cell with hres flipped mid-cell: spacing and content must stay 40-col
        run_cell("flip",    0, 1'b1, 1'b0, 1'b0, 8'h1E, 8'hA5, 5'h00, 1'b0, 32'hE1E11E1E, 8, 1'b1);

        // Reset pulse 7 clocks into a solid-white 40-col cell
        set_inputs(0, 1'b1, 1'b0, 1'b0, 8'h0F, 8'hFF, 5'h00, 1'b0);
        begin : find_cell
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 70 && !hit; i++) begin
                @(negedge clk);
                hit = (bus.load === 1'b1) && (bus.lclk === 1'b1);
            end
            check("midrst_lclk_found", 32'(hit), 32'(1));
        end
        repeat (7) @(negedge clk);
        check("midrst_pre_video", 32'(bus.video), 32'hF);
        reset = 1'b1;
        #1;
        check("midrst_video",  32'(bus.video),  32'h0);
        check("midrst_pix_ce", 32'(bus.pix_ce), 32'h0);
        check("midrst_load",   32'(bus.load),   32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            check_strobes("after_rst", k, 1'b0);
            check("after_rst_video", 32'(bus.video), (k >= 32) ? 32'hF : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cga_sequencer.md
CGA_SEQUENCER -- requirements
Module: cga_sequencer

Interface
REQ-001 clk  input  1  28.636 MHz master clock; all logic on rising edge.
REQ-002 reset  input  1  reset is asynchronous and active-high.
REQ-003 hres_mode  input  1  1 = 80-column text timing; 0 = 40-column.
REQ-004 grph_mode / grph_640  input  1 each  graphics mode; 640x200 1 bpp when grph_640=1, else 320x200 2 bpp.
REQ-005 display_enable, cursor, blink  input  1 each  active region, cursor cell, blink phase; sampled on load.
REQ-006 char_byte, attr_byte, pix_byte  input  8 each  text char, text attribute, font row or graphics byte; valid on the load cycle.
REQ-007 color_sel  input  5  border/background colour [3:0] plus palette intensity [4].
REQ-008 pal_sel  input  1  320-mode palette select.
REQ-009 load  output  1  one-clk fetch strobe at each cell boundary.
REQ-010 hclk, lclk  output  1 each  one-clk enables every 16 and 32 clk respectively.
REQ-011 pix_ce  output  1  pixel enable.
REQ-012 video  output  4  registered IRGB pixel to the composite encoder.

Function
REQ-013 A free-running 5-bit dot counter shall increment every clk and wrap from 31 to 0.
REQ-014 hclk shall pulse when counter[3:0]==15; lclk shall pulse when counter==31.
REQ-015 pix_ce shall pulse every 2 clk (counter[0]==1) in hres text and 640 modes, and every 4 clk (counter[1:0]==3) otherwise.
REQ-016 load shall equal lclk in 40-column text and hclk in all other modes; load always coincides with a pix_ce.
REQ-017 On load, the block shall latch attribute/colour state and load the 8-bit shifter from pix_byte; mode inputs take effect only at the next load.
REQ-018 video shall update only on pix_ce, one clk after it; the pix_ce coincident with load shall output pixel 0 (MSB) of the new cell.
REQ-019 Text: shifter bit 1 selects fg = attr[3:0]; bit 0 selects bg = {attr[7], attr[6:4]}; 8 pixels per cell.
REQ-020 Text cursor: when cursor=1 and blink=1 at load, all 8 pixels of the cell shall be fg.
REQ-021 320 mode: shift 2 bits per pix_ce (4 pixels per byte); value 0 -> color_sel[3:0]; values 1..3 -> {color_sel[4], colour}, where colour is green/red/brown (2,4,6) for pal_sel=0 and cyan/magenta/white (3,5,7) for pal_sel=1.
REQ-022 640 mode: 1 bit per pix_ce; 0 -> 4'h0; 1 -> color_sel[3:0].
REQ-023 display_enable=0 at load: the whole cell shall be border colour color_sel[3:0], or 4'h0 in 640 mode; cursor is ignored.
REQ-024 A mode change between loads shall not alter pix_ce spacing until the counter reaches the next load boundary, so no pixel is truncated or duplicated.

Reset
REQ-025 While reset is high: counter=0; video=4'h0; load, hclk, lclk, pix_ce=0; shifter and latches=0.
REQ-026 After reset deasserts: the first hclk shall occur 16 clk later and the first lclk 32 clk later.
REQ-027 Reset asserted mid-cell shall abort the cell immediately, with no partial pixel output afterwards.

Configuration
REQ-028 With CGA_BLINK_EN defined, attr[7] shall be a blink flag: bg intensity forced to 0, and when attr[7]=1 and blink=0 the fg pixels shall show bg.
REQ-029 Without CGA_BLINK_EN, attr[7] shall be the bg intensity per REQ-019 and blink shall affect only the cursor.

Structure
REQ-030 Shared package cga_pkg shall hold the IRGB colour constants, the 320-mode palette table and the counter decode constants (15, 31).
REQ-031 The counter and the hclk/lclk/pix_ce/load decode shall be sub-module cga_clk_en; colour selection and shifting remain in cga_sequencer.

Verification
REQ-032 Release reset, hres text -> hclk at clk 16, 32, 48; lclk at 32, 64; pix_ce every 2 clk.
REQ-033 80-col text, pix_byte=8'hA5, attr=8'h1E, enable=1 -> video sequence E,1,E,1,1,E,1,E with one pixel per pix_ce.
REQ-034 320 mode, pix_byte=8'h1B, color_sel=5'h11, pal_sel=1 -> video 1,B,D,F.
REQ-035 40-col text, cursor=1, blink=1, pix_byte=0, attr=8'h07 -> all 8 pixels =7; with display_enable=0 -> all pixels = color_sel[3:0].
REQ-036 CGA_BLINK_EN defined, attr=8'h8F, blink=0, pix_byte=8'hFF -> video 0 for the whole cell; undefined -> F.
REQ-037 reset pulse at clk 7 of a cell -> video 0 on the next clk and counter restarts at 0.
